// File: rtl/wb_host_master_if.sv
// wb_host_master_if
//   Bundles the request channel, response channel and Wishbone classic
//   master signals of wb_host_master.
//   master modport : the initiator view (wb_host_master itself).
//   slave modport  : the opposite view (request source, response sink and
//                    Wishbone slave combined, e.g. a bench or bridge).
//   Signals:
//     req_valid/req_ready/req_we/req_adr/req_dat/req_sel  request channel
//     rsp_valid/rsp_ready/rsp_dat/rsp_err/rsp_timeout    response channel
//     wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o             Wishbone outputs
//     wbm_dat_i/ack_i/err_i                              Wishbone inputs
//     busy                                               controller not idle
interface wb_host_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_dat;
  logic [SEL_W-1:0]  req_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [SEL_W-1:0]  wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_err_i;

  logic              busy;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, req_sel,
    input  rsp_ready,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output req_ready,
    output rsp_valid, rsp_dat, rsp_err, rsp_timeout,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output busy
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, req_sel,
    output rsp_ready,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  req_ready,
    input  rsp_valid, rsp_dat, rsp_err, rsp_timeout,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  busy
  );
endinterface

// File: rtl/wb_host_master.sv
// wb_host_master
//   Converts one valid/ready request into exactly one Wishbone classic
//   (non-pipelined) read or write and returns the outcome on a valid/ready
//   response channel. One transaction outstanding at most; an optional
//   timeout ends a bus cycle that never receives ack/err.
//   Ports:
//     wb_clk_i   clock, rising edge
//     wb_rst_ni  asynchronous active-low reset
//     bus        wb_host_master_if.master (request, response, Wishbone, busy)
//   Parameters: ADDR_W, DATA_W (multiple of 8), TIMEOUT (0 = no timeout).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | req_ready high, waiting for a request
//   ST_BUS  | cyc/stb high, waiting for ack/err or timeout
//   ST_RESP | rsp_valid high, holding the response until rsp_ready
module wb_host_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_host_master_if.master bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_dat_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              timeout_hit;

  // cnt_q counts completed BUS cycles; the timeout fires on the edge that
  // closes cycle number TIMEOUT, so cyc stays high exactly TIMEOUT cycles.
  always_comb begin
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_LIMIT);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            state_q     <= ST_BUS;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cyc_q       <= 1'b1;
            we_q        <= bus.req_we;
            adr_q       <= bus.req_adr;
            dat_q       <= bus.req_dat;
            sel_q       <= bus.req_sel;
            cnt_q       <= '0;
          end
        end

        ST_BUS: begin
          // err has priority over ack; ack on the last allowed cycle still
          // beats the timeout.
          if (bus.wbm_err_i || bus.wbm_ack_i || timeout_hit) begin
            state_q       <= ST_RESP;
            cyc_q         <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.wbm_err_i || !bus.wbm_ack_i;
            rsp_timeout_q <= !bus.wbm_err_i && !bus.wbm_ack_i;
            rsp_dat_q     <= (bus.wbm_ack_i && !bus.wbm_err_i && !we_q) ?
                             bus.wbm_dat_i : '0;
          end
          cnt_q <= cnt_d;
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = cyc_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_dat     = rsp_dat_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic (B4, non-pipelined) initiator that drives a single-transfer bus cycle toward a Wishbone slave, e.g. the user-project slave port (wbs_*) in simulation harnesses and on-chip test paths.
- A simple valid/ready request channel (fed by LA bits, a UART bridge or a bench) is converted into exactly one Wishbone read or write.
- Result returned on a valid/ready response channel. At most one outstanding transaction; bus timeout guard.

Parameters:
- ADDR_W, 32, address width of req_adr / wbm_adr_o
- DATA_W, 32, data width; must be a multiple of 8; SEL_W = DATA_W/8
- TIMEOUT, 255, max cycles cyc/stb stay high waiting for ack/err; 0 disables timeout

Ports:
- wb_clk_i  in  1  clock; all logic rising-edge
- wb_rst_ni  in  1  asynchronous active-low reset; assertion async, deassertion sampled on wb_clk_i
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready at an edge
- req_we  in  1  1=write, 0=read
- req_adr  in  ADDR_W  target address
- req_dat  in  DATA_W  write data
- req_sel  in  SEL_W  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_dat  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  1 = slave err or timeout
- rsp_timeout  out  1  1 = error caused by timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master controls
- wbm_sel_o  out  SEL_W
- wbm_adr_o  out  ADDR_W
- wbm_dat_o  out  DATA_W
- wbm_dat_i  in  DATA_W
- wbm_ack_i  in  1
- wbm_err_i  in  1  tie 0 if slave has none
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0, except req_ready=1 (IDLE). State=IDLE; timeout counter=0.
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On accept edge: latch we/adr/dat/sel into wbm_* outputs, assert cyc=stb=1, go BUS. cyc/stb visible from the cycle after the accept edge.
- BUS:
  - req_ready=0; wbm_* held stable; counter increments each cycle.
  - wbm_ack_i=1 sampled at an edge: cyc=stb=0 next cycle. rsp_dat = wbm_dat_i for reads, 0 for writes. rsp_err=0. Go RESP.
  - wbm_err_i=1 (without ack): same exit path, but rsp_err=1 and rsp_dat=0.
  - ack and err high together: err wins.
  - TIMEOUT≠0 and counter reaches TIMEOUT with no ack/err: drop cyc/stb, rsp_err=1, rsp_timeout=1, rsp_dat=0, go RESP.
  - Minimum bus cycle is 1 clock (ack in first cycle). An ack on the final timeout cycle counts as success.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0, rsp_err/rsp_timeout cleared, counter cleared, return to IDLE (req_ready=1 next cycle).
  - No request overlap: next accept is earliest 1 cycle after the response handshake.
- wbm_ack_i/err_i outside BUS: ignored, no state change.
- Counter width: clog2(TIMEOUT+1), saturating; no wrap-around possible.
- Reset mid-transaction: cyc/stb fall asynchronously; pending response discarded; FSM returns to IDLE.
- Latency, zero-wait slave:
  - accept edge N → cyc high in cycle N+1 → ack sampled at edge N+1 → rsp_valid high in cycle N+2 → with rsp_ready=1, IDLE at N+3.

Test Plan:
- Write, zero-wait: req we=1 adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF; slave acks first cycle → cyc high exactly 1 cycle with those values; rsp_valid cycle N+2, rsp_err=0, rsp_dat=0.
- Read with 3 wait states: slave returns 0xCAFE_F00D on the 4th cycle → cyc/stb high 4 cycles, adr stable; rsp_dat=0xCAFE_F00D; req_ready=0 throughout.
- Timeout: TIMEOUT=8, slave never acks → cyc drops after 8 cycles; rsp_err=1, rsp_timeout=1, rsp_dat=0. Late ack afterwards → no effect.
- Backpressure: rsp_ready held 0 for 5 cycles while req_valid stays 1 → rsp fields stable; no new cyc. Second request accepted only after the response handshake.
- Slave err plus simultaneous ack/err → rsp_err=1, rsp_timeout=0, rsp_dat=0.
- Async reset asserted mid-BUS (slave stalled) → cyc/stb=0 without a clock edge; after release req_ready=1, rsp_valid=0; next write completes normally.
